// File: rtl/sockit_ghrd_fpgamem_system_pio_pkg.sv
// Register map and bus constants shared by the button PIO slice.
package sockit_ghrd_fpgamem_system_pio_pkg;

  localparam int unsigned READDATA_W = 32;
  localparam int unsigned ADDR_W     = 2;

  // Avalon-MM word addresses
  localparam logic [ADDR_W-1:0] DATA     = 2'd0;
  localparam logic [ADDR_W-1:0] DIR      = 2'd1;
  localparam logic [ADDR_W-1:0] IRQ_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] EDGE_CAP = 2'd3;

endpackage

// File: rtl/sockit_ghrd_fpgamem_system_button_pio_debounce.sv
// One-bit debouncer: the output follows the input only after the input has
// differed from it for DEBOUNCE_CYCLES consecutive clocks.
module sockit_ghrd_fpgamem_system_button_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt;

  // Count consecutive mismatching clocks; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= RESET_LEVEL;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      stable <= din;
      cnt    <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sockit_ghrd_fpgamem_system_button_pio.sv
// Avalon-MM button PIO: synchronised inputs, edge capture with write-1-to-clear,
// interrupt mask and level irq. Optional per-bit debounce is enabled by defining
// SOCKIT_GHRD_FPGAMEM_SYSTEM_BUTTON_PIO_DEBOUNCE_EN.
module sockit_ghrd_fpgamem_system_button_pio
  import sockit_ghrd_fpgamem_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          EDGE_FALLING    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [READDATA_W-1:0] writedata,
  output logic [READDATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  // Idle level of the keys: released active-low keys read high.
  localparam logic [WIDTH-1:0] INACTIVE = {WIDTH{EDGE_FALLING}};

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_flag;
  logic [WIDTH-1:0] clear_mask;
  logic             wr_en;
  logic             writedata_unused;

  // Only the low WIDTH bits of writedata carry register content.
  assign writedata_unused = ^writedata;

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync0 <= INACTIVE;
      sync1 <= INACTIVE;
    end else begin
      sync0 <= in_port;
      sync1 <= sync0;
    end
  end

`ifdef SOCKIT_GHRD_FPGAMEM_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
  // One debouncer per input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    sockit_ghrd_fpgamem_system_button_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (EDGE_FALLING)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync1[i]),
      .stable  (stable[i])
    );
  end
`else
  localparam int unsigned dbc_unused = DEBOUNCE_CYCLES;
  assign stable = sync1;
`endif

  // One-clock-delayed copy of the stable level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) prev <= INACTIVE;
    else          prev <= stable;
  end

  // Edge flags, bus write decode and write-1-to-clear mask.
  always_comb begin
    edge_flag  = EDGE_FALLING ? (prev & ~stable) : (~prev & stable);
    wr_en      = chipselect & ~write_n;
    clear_mask = '0;
    if (wr_en && (address == EDGE_CAP)) clear_mask = writedata[WIDTH-1:0];
  end

  // Mask and capture registers; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (address == IRQ_MASK)) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clear_mask) | edge_flag;
    end
  end

  // Registered read mux, one wait state, independent of chipselect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        DATA:     readdata <= READDATA_W'(stable);
        DIR:      readdata <= '0;
        IRQ_MASK: readdata <= READDATA_W'(irq_mask);
        EDGE_CAP: readdata <= READDATA_W'(edge_capture);
        default:  readdata <= '0;
      endcase
    end
  end

  // Level interrupt from registered capture and mask only.
  always_ff @(posedge clk) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edge_capture & irq_mask);
  end

endmodule

// File: tb/tb_sockit_ghrd_fpgamem_system_button_pio.sv
// Bench for the button PIO: directed register/edge scenarios plus randomized
// bus and input traffic compared against a behavioural model.
module tb_sockit_ghrd_fpgamem_system_button_pio;
  import sockit_ghrd_fpgamem_system_pio_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DBC   = 8;
  localparam logic [WIDTH-1:0] INACT = '1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [WIDTH-1:0] in_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Model state: input pipeline, accepted level, previous level, registers.
  logic [WIDTH-1:0] m_s0, m_s1, m_stable, m_prev, m_mask, m_cap;
  logic [31:0]      m_rd;
  logic             m_irq;
  int               m_run [WIDTH];

  always #5 clk = ~clk;

  sockit_ghrd_fpgamem_system_button_pio #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DBC),
    .EDGE_FALLING    (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and move the model by the same clock.
  task automatic tick();
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] n_cap;
    logic [31:0]      n_rd;
    logic             n_irq;
    @(posedge clk);
    if (!reset_n) begin
      m_s0 = INACT; m_s1 = INACT; m_stable = INACT; m_prev = INACT;
      m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      case (address)
        DATA:     n_rd = 32'(m_stable);
        DIR:      n_rd = 32'd0;
        IRQ_MASK: n_rd = 32'(m_mask);
        default:  n_rd = 32'(m_cap);
      endcase
      n_irq = (m_cap & m_mask) != '0;
      clr   = (chipselect && !write_n && address == EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
      // keys that went from released (1) to pressed (0) are captured
      n_cap = (m_cap & ~clr) | (m_prev & ~m_stable);
      if (chipselect && !write_n && address == IRQ_MASK) m_mask = writedata[WIDTH-1:0];
      m_prev = m_stable;
`ifdef SOCKIT_GHRD_FPGAMEM_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
      for (int i = 0; i < WIDTH; i++) begin
        if (m_s1[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DBC) begin
            m_stable[i] = m_s1[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s1 = m_s0;
      m_s0 = in_port;
`else
      m_s1     = m_s0;
      m_s0     = in_port;
      m_stable = m_s1;
`endif
      m_cap = n_cap; m_rd = n_rd; m_irq = n_irq;
    end
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    logic [31:0] exp_data;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = DATA;
    writedata = '0; in_port = INACT;
    tick(); tick();
    check("reset_rd", readdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;

    rd_check("rst_data", DATA, 32'h0000000F);
    rd_check("rst_mask", IRQ_MASK, 32'd0);
    rd_check("rst_cap", EDGE_CAP, 32'd0);
    check("rst_irq2", 32'(irq), 32'd0);

`ifndef SOCKIT_GHRD_FPGAMEM_SYSTEM_BUTTON_PIO_DEBOUNCE_EN
    // Single falling edge on bit 1: captured at the third clock, irq one later.
    bus_write(IRQ_MASK, 32'h2);
    address = EDGE_CAP;
    in_port = 4'hD;
    tick(); tick(); tick();
    check("cap_clk3_rd", readdata, 32'd0);
    check("cap_clk3_irq", 32'(irq), 32'd0);
    tick();
    check("cap_clk4_rd", readdata, 32'h2);
    check("cap_clk4_irq", 32'(irq), 32'd1);
    bus_write(EDGE_CAP, 32'h2);
    tick();
    check("clr_rd", readdata, 32'd0);
    check("clr_irq", 32'(irq), 32'd0);
    bus_write(EDGE_CAP, 32'h2);
    tick();
    check("held_no_recap", readdata, 32'd0);

    // Edge on bit 0 landing in the same clock as its clear stays captured.
    in_port = 4'hE;
    tick(); tick();
    bus_write(EDGE_CAP, 32'h1);
    tick();
    check("simul_set_wins", readdata, 32'h1);
    check("simul_irq_masked", 32'(irq), 32'd0);
    exp_data = 32'hE;
`else
    // Short glitch rejected, long press accepted.
    address = EDGE_CAP;
    in_port = 4'hB;
    repeat (5) tick();
    in_port = 4'hF;
    repeat (20) tick();
    check("glitch_rejected", readdata, 32'd0);
    in_port = 4'hB;
    repeat (14) tick();
    check("press_captured", readdata, 32'h4);
    rd_check("press_data", DATA, 32'hB);
    exp_data = 32'hB;
`endif

    // Read-only registers ignore writes; mask keeps only WIDTH bits.
    bus_write(DATA, 32'hFFFFFFFF);
    bus_write(DIR, 32'hFFFFFFFF);
    rd_check("ro_data", DATA, exp_data);
    rd_check("ro_dir", DIR, 32'd0);
    bus_write(IRQ_MASK, 32'hFFFFFFFF);
    rd_check("mask_rw", IRQ_MASK, 32'h0000000F);

    // Capture all bits, then a one-clock reset pulse clears everything.
    in_port = 4'hF;
    repeat (20) tick();
    in_port = 4'h0;
    repeat (20) tick();
    rd_check("all_cap", EDGE_CAP, 32'h0000000F);
    tick();
    check("all_irq", 32'(irq), 32'd1);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick();
    reset_n = 1'b1;
    check("pulse_irq", 32'(irq), 32'd0);
    rd_check("pulse_cap", EDGE_CAP, 32'd0);
    rd_check("pulse_mask", IRQ_MASK, 32'd0);
    repeat (15) tick();
    rd_check("no_reset_edge", EDGE_CAP, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset_n    = ($urandom_range(0, 499) != 0);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 11) == 0)
        in_port = in_port ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      tick();
      check("rand_rd", readdata, m_rd);
      check("rand_irq", 32'(irq), 32'(m_irq));
    end
    reset_n = 1'b1;
    chipselect = 1'b0;
    write_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sockit_ghrd_fpgamem_system_button_pio.md
SOCKIT_GHRD_FPGAMEM_SYSTEM_BUTTON_PIO -- requirements
Module: sockit_ghrd_fpgamem_system_button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable clocks (1 ms at 50 MHz) required to accept a level change.
REQ-003 SHALL have parameter EDGE_FALLING, default 1; 1 = capture falling edges (active-low keys), 0 = capture rising edges.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 in_port  input  WIDTH  asynchronous board inputs.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 SHALL synchronize in_port through two flops (sync0, sync1) before any use.
REQ-014 SHALL produce per-bit stable value "stable" (debounced per REQ-026, else sync1) and a one-clock-delayed copy "prev".
REQ-015 SHALL flag an edge on bit i when stable[i]=0 and prev[i]=1 (EDGE_FALLING=1), or stable[i]=1 and prev[i]=0 (EDGE_FALLING=0).
REQ-016 Map: 0 = data (RO, stable); 1 = direction (RO, reads 0); 2 = irq_mask (RW, WIDTH bits); 3 = edge_capture (RO, write-1-to-clear).
REQ-017 Write occurs when chipselect=1 and write_n=0; writes to addresses 0 and 1 SHALL be ignored.
REQ-018 edge_capture[i] SHALL set on a flagged edge and clear on a write to address 3 with writedata[i]=1; a simultaneous edge and clear SHALL leave the bit set.
REQ-019 readdata SHALL update every clock with the value selected by the current address, zero-extended to 32 bits; data is valid one clock after address is presented (one read wait state), independent of chipselect.
REQ-020 irq SHALL equal OR-reduce(edge_capture & irq_mask), driven from registers with no combinational path from bus inputs.
REQ-021 Without debounce, a single in_port transition SHALL set edge_capture on the third rising clk after the transition.
REQ-022 A bit held at a level SHALL produce exactly one capture per transition; repeated set/clear with no new edge SHALL leave the bit clear.

Reset
REQ-023 While reset_n=0 at a rising clk: sync0, sync1, stable, prev SHALL load the inactive level (all 1s when EDGE_FALLING=1, all 0s otherwise); irq_mask, edge_capture, readdata, debounce counters SHALL load 0; irq SHALL be 0 the following cycle.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be flagged from the reset-to-input transition while in_port sits at the inactive level.

Configuration
REQ-025 Macro SOCKIT_GHRD_FPGAMEM_SYSTEM_BUTTON_PIO_DEBOUNCE_EN selects debounce.
REQ-026 Defined: per-bit counter, width ceil(log2(DEBOUNCE_CYCLES+1)), increments while sync1[i] != stable[i], resets to 0 when equal; when count reaches DEBOUNCE_CYCLES-1, stable[i] <= sync1[i] and counter clears; counter SHALL saturate and never wrap.
REQ-027 Undefined: stable = sync1; DEBOUNCE_CYCLES unused; no counter logic synthesized.

Structure
REQ-028 Package sockit_ghrd_fpgamem_system_pio_pkg SHALL hold register address constants (DATA=0, DIR=1, IRQ_MASK=2, EDGE_CAP=3) and the readdata width constant.
REQ-029 Debounce SHALL be sub-module sockit_ghrd_fpgamem_system_button_pio_debounce (one bit, parameter DEBOUNCE_CYCLES), instantiated WIDTH times under the macro.

Verification
REQ-030 Reset, no debounce, in_port=4'hF: read address 0 -> 0x0000000F; addresses 2, 3 -> 0; irq=0.
REQ-031 No debounce, irq_mask=4'h2, in_port[1] 1->0: edge_capture=0x2 at third clk, irq=1 next cycle; write 0x2 to address 3 -> edge_capture=0, irq=0.
REQ-032 Simultaneous: edge on bit 0 flagged in same clock as write 0x1 to address 3 -> edge_capture[0] stays 1.
REQ-033 Debounce enabled, DEBOUNCE_CYCLES=8: in_port[2] glitch low for 5 clocks -> no capture; held low 12 clocks -> edge_capture=0x4, data bit 2 reads 0.
REQ-034 Write 0xFFFFFFFF to address 0 and 1 -> reads unchanged (data=stable, direction=0); write 0xFFFFFFFF to address 2 -> reads 0x0000000F.
REQ-035 reset_n pulsed low for one clock with edge_capture=0xF and irq_mask=0xF -> both 0, irq=0 next cycle.
